instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction-word encoder for the RISC-V single-cycle core's test and boot path. It takes format-tagged operand bundles (opcode, register indices, funct fields, 32-bit immediate) over a valid/ready stream and emits packed 32-bit instruction words. It range-checks every immediate, and expands the `LI` pseudo-op into `LUI`/`ADDI` when needed. It is the packing counterpart of the core's immediate extender, and uses the same format codes.

## Interface
Parameters:
- `NOP_WORD`, default `32'h0000_0013`. Word emitted on an encoding error.

Ports (direction, width, meaning):
- `clk`, in, 1. Clock, rising edge.
- `rst_n`, in, 1. Reset, asynchronous, active-low.
- `in_valid`, in, 1. Input bundle valid.
- `in_ready`, out, 1. Input accepted when `in_valid & in_ready`.
- `in_fmt`, in, 3. Format code:
  - `000` I
  - `001` S
  - `101` B
  - `010` U
  - `110` J
  - `111` LI pseudo
  - `011`, `100` illegal
- `in_opcode`, in, 7. Opcode. Ignored for LI.
- `in_funct3`, in, 3. funct3.
- `in_funct7`, in, 7. Upper field for I-type shifts (funct3 `001`/`101`).
- `in_rd`, `in_rs1`, `in_rs2`, in, 5 each. Register indices.
- `in_imm`, in, 32. Immediate, two's complement.
- `out_valid`, out, 1. Output word valid.
- `out_ready`, in, 1. Downstream accept.
- `out_instr`, out, 32. Packed instruction.
- `out_err`, out, 1. Immediate not encodable, or illegal format. Qualified by `out_valid`.
- `out_last`, out, 1. Final word of the bundle.

## Operation
- Standard RV32I field placement: `opcode[6:0]`, `rd[11:7]`, `funct3[14:12]`, `rs1[19:15]`, `rs2[24:20]`.
- I-type:
  - Non-shift: `imm[11:0]` goes to `[31:20]`. Legal range -2048..2047.
  - Shift (funct3 `001`/`101`): `imm[4:0]` goes to `[24:20]` and `in_funct7` to `[31:25]`. Legal range 0..31.
- S-type: `imm[11:5]` to `[31:25]`, `imm[4:0]` to `[11:7]`. Legal range -2048..2047.
- B-type:
  - Field map: `imm[12]` to `[31]`, `imm[10:5]` to `[30:25]`, `imm[4:1]` to `[11:8]`, `imm[11]` to `[7]`.
  - Legal: signed 13-bit range and `imm[0]==0`.
- U-type: `imm[31:12]` to `[31:12]`. Legal only if `imm[11:0]==0`.
- J-type:
  - Field map: `imm[20]` to `[31]`, `imm[10:1]` to `[30:21]`, `imm[11]` to `[20]`, `imm[19:12]` to `[19:12]`.
  - Legal: signed 21-bit range and `imm[0]==0`.
- Error handling: on an illegal immediate or illegal format, emit `NOP_WORD` with `out_err=1` and `out_last=1`. There is no retry.
- LI expansion (uses `rd` and `imm` only):
  - If `imm` is in -2048..2047: one word, `ADDI rd,x0,imm`.
  - Else if `imm[11:0]==0`: one word, `LUI rd,imm[31:12]`.
  - Else two words:
    - First: `LUI rd,hi` with `hi=(imm+32'h800)[31:12]`, arithmetic mod 2^32.
    - Second: `ADDI rd,rd,imm[11:0]`.
    - `out_last=0` on the first word, 1 on the second.
  - LI never sets `out_err`.
- FSM states:
  - `S_RUN`:
    - Accepts input when `in_ready`.
    - A two-word LI loads the LUI into the output register and moves to `S_LO`.
  - `S_LO`:
    - `in_ready=0`.
    - On output handshake, loads the ADDI (precomputed and held in an internal register) and returns to `S_RUN`.

## Timing
- Registered output. A bundle accepted at edge N shows `out_valid=1` after edge N.
- Second LI word appears the cycle after the first word's handshake.
- `in_ready = (state==S_RUN) & (~out_valid | out_ready)`.
  - Back-to-back accept and emit is possible: full throughput of 1 word/cycle.
- Output stall: while `out_valid & ~out_ready`, `out_instr`, `out_err` and `out_last` hold stable.
- Simultaneous accept and output handshake in `S_RUN`: the new word replaces the old in the same edge, with no bubble.
- Reset, asynchronous, any cycle (including mid-LI in `S_LO`):
  - `state=S_RUN`, `out_valid=0`, `out_instr=0`, `out_err=0`, `out_last=0`.
  - Any pending ADDI is discarded.
  - `in_ready` rises combinationally once reset is released.
- Range checks and packing are combinational on the input side; the only pipeline stage is the output register.

## Structure
- Shared package `riscv_pkg` holds:
  - Format-code constants (`FMT_I`, `FMT_S`, `FMT_B`, `FMT_U`, `FMT_J`, `FMT_LI`), shared with the extender.
  - Opcode constants `OP_LUI=7'b0110111` and `OP_IMM=7'b0010011`.
  - The `state_t` enum.
- One combinational sub-module, `imm_pack`. Inputs are fmt, funct3, funct7 and imm. Outputs are the 32-bit immediate-bit mask/value and `fits`. The top level ORs in the register and opcode fields.

## Test plan
- I-type, opcode `0x13`, funct3 0, `rd=1`, `rs1=0`, `imm=-1` -> `0xFFF00093`, `out_err=0`, `out_last=1`, one cycle after accept.
- B-type, opcode `0x63`, funct3 0, `rs1=1`, `rs2=2`:
  - `imm=8` -> `0x00208463`.
  - Same bundle with `imm=3` -> `0x00000013`, `out_err=1`.
- J-type, opcode `0x6F`, `rd=1`, `imm=0x800` -> `0x001000EF`.
- LI `rd=5`, `imm=0x12345FFF` -> `0x123462B7` (`out_last=0`), then `0xFFF28293` (`out_last=1`).
  - Hold `out_ready=0` for 3 cycles on each word: words stay stable and `in_ready` stays 0 throughout `S_LO`.
- LI `imm=0x7FF` -> single `0x7FF00013`-form ADDI with `rd` set. LI `imm=0x00010000` -> single LUI.
- Assert `rst_n=0` while in `S_LO`, then release -> `out_valid=0` and no ADDI emitted.
  - Next bundle (U-type, `imm=0x1000`, `rd=2`, opcode `0x37`) -> `0x00001137`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants: format codes (common with the immediate
// extender), opcodes used by LI expansion, and the encoder FSM state type.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] FMT_I  = 3'b000;
  localparam logic [2:0] FMT_S  = 3'b001;
  localparam logic [2:0] FMT_B  = 3'b101;
  localparam logic [2:0] FMT_U  = 3'b010;
  localparam logic [2:0] FMT_J  = 3'b110;
  localparam logic [2:0] FMT_LI = 3'b111;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  typedef enum logic [0:0] {
    S_RUN = 1'b0,
    S_LO  = 1'b1
  } state_t;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Places immediate bits into their instruction-word positions per format and
// reports whether the immediate is representable in that format.
module imm_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        fits
);

  logic fits12;
  logic fits13;
  logic fits21;
  logic is_shift;

  // Signed range checks: all bits above the sign bit must equal it.
  assign fits12   = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13   = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21   = (&imm[31:20]) | ~(|imm[31:20]);
  assign is_shift = (funct3 == F3_SLLI) || (funct3 == F3_SRXI);

  always_comb begin
    imm_bits = '0;
    fits     = 1'b0;
    case (fmt)
      FMT_I: begin
        if (is_shift) begin
          imm_bits = {funct7, imm[4:0], 20'b0};
          fits     = ~(|imm[31:5]);
        end else begin
          imm_bits = {imm[11:0], 20'b0};
          fits     = fits12;
        end
      end
      FMT_S: begin
        imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        fits     = fits12;
      end
      FMT_B: begin
        imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        fits     = fits13 & ~imm[0];
      end
      FMT_U: begin
        imm_bits = {imm[31:12], 12'b0};
        fits     = ~(|imm[11:0]);
      end
      FMT_J: begin
        imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        fits     = fits21 & ~imm[0];
      end
      default: begin
        imm_bits = '0;
        fits     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams format-tagged operand bundles into packed RV32I instruction words,
// expanding LI into LUI/ADDI and substituting NOP_WORD for unencodable input.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  state_t      state_q, state_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] instr_d;
  logic        valid_d, err_d, last_d;

  logic [31:0] pack_bits;
  logic        pack_fits;
  logic [31:0] word_c;
  logic [31:0] lo_word_c;
  logic        err_c;
  logic        two_word_c;
  logic [19:0] li_hi;
  logic        accept;
  logic        out_hs;

  imm_pack u_imm_pack (
    .fmt      (in_fmt),
    .funct3   (in_funct3),
    .funct7   (in_funct7),
    .imm      (in_imm),
    .imm_bits (pack_bits),
    .fits     (pack_fits)
  );

  // Rounded upper part so that LUI hi + sign-extended imm[11:0] == imm.
  assign li_hi    = in_imm[31:12] + 20'(in_imm[11]);
  assign in_ready = (state_q == S_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  // Input-side packing: immediate bits from imm_pack OR'd with register fields.
  always_comb begin
    word_c     = '0;
    lo_word_c  = '0;
    err_c      = 1'b0;
    two_word_c = 1'b0;
    case (in_fmt)
      FMT_I: begin
        word_c = pack_bits | {12'b0, in_rs1, in_funct3, in_rd, in_opcode};
        err_c  = ~pack_fits;
      end
      FMT_S, FMT_B: begin
        word_c = pack_bits | {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, in_opcode};
        err_c  = ~pack_fits;
      end
      FMT_U, FMT_J: begin
        word_c = pack_bits | {20'b0, in_rd, in_opcode};
        err_c  = ~pack_fits;
      end
      FMT_LI: begin
        if ((&in_imm[31:11]) || !(|in_imm[31:11])) begin
          word_c = {in_imm[11:0], 5'b0, 3'b000, in_rd, OP_IMM};
        end else if (!(|in_imm[11:0])) begin
          word_c = {in_imm[31:12], in_rd, OP_LUI};
        end else begin
          word_c     = {li_hi, in_rd, OP_LUI};
          lo_word_c  = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_IMM};
          two_word_c = 1'b1;
        end
      end
      default: err_c = 1'b1;
    endcase
    if (err_c) begin
      word_c = NOP_WORD;
    end
  end

  // Next-state and output-register update.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    valid_d = out_valid;
    instr_d = out_instr;
    err_d   = out_err;
    last_d  = out_last;
    case (state_q)
      S_RUN: begin
        if (accept) begin
          valid_d = 1'b1;
          instr_d = word_c;
          err_d   = err_c;
          last_d  = ~two_word_c;
          if (two_word_c) begin
            lo_d    = lo_word_c;
            state_d = S_LO;
          end
        end else if (out_hs) begin
          valid_d = 1'b0;
        end
      end
      S_LO: begin
        if (out_hs) begin
          valid_d = 1'b1;
          instr_d = lo_q;
          err_d   = 1'b0;
          last_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      lo_q      <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      out_valid <= valid_d;
      out_instr <= instr_d;
      out_err   <= err_d;
      out_last  <= last_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected words queued at drive time and
// popped against the DUT output register.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  instr_encoder #(.NOP_WORD(32'h0000_0013)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] instr, input logic err, input logic last);
    exp_t e;
    e.instr = instr;
    e.err   = err;
    e.last  = last;
    sb.push_back(e);
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    in_fmt    = fmt;
    in_opcode = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Compare the current output register against the scoreboard head.
  task automatic check_out(output exp_t e);
    e = '0;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_instr", out_instr, e.instr);
      chk("out_err", 32'(out_err), 32'(e.err));
      chk("out_last", 32'(out_last), 32'(e.last));
    end
  endtask

  // Check the word now present, stall it, then complete the handshake.
  task automatic recv(input int stall);
    exp_t e;
    out_ready = 1'b0;
    check_out(e);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_instr", out_instr, e.instr);
      chk("stall_last", 32'(out_last), 32'(e.last));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_fmt    = '0;
    in_opcode = '0;
    in_funct3 = '0;
    in_funct7 = '0;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_imm    = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // I-type addi x1,x0,-1
    expect_word(32'hFFF0_0093, 1'b0, 1'b1);
    send(3'b000, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    recv(0);

    // B-type legal and misaligned
    expect_word(32'h0020_8463, 1'b0, 1'b1);
    send(3'b101, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    recv(0);
    expect_word(32'h0000_0013, 1'b1, 1'b1);
    send(3'b101, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    recv(0);

    // J-type
    expect_word(32'h0010_00EF, 1'b0, 1'b1);
    send(3'b110, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    recv(0);

    // Two-word LI with stalls on both words
    expect_word(32'h1234_62B7, 1'b0, 1'b0);
    expect_word(32'hFFF2_8293, 1'b0, 1'b1);
    send(3'b111, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    recv(3);
    recv(3);

    // Single-word LI forms
    expect_word(32'h7FF0_0193, 1'b0, 1'b1);
    send(3'b111, 7'h00, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h0000_07FF);
    recv(0);
    expect_word(32'h0001_0237, 1'b0, 1'b1);
    send(3'b111, 7'h00, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'h0001_0000);
    recv(0);

    // Shift immediate out of range, then illegal format
    expect_word(32'h0000_0013, 1'b1, 1'b1);
    send(3'b000, 7'h13, 3'b001, 7'd0, 5'd1, 5'd1, 5'd0, 32'd32);
    recv(0);
    expect_word(32'h0000_0013, 1'b1, 1'b1);
    send(3'b011, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd0);
    recv(0);

    // Back-to-back throughput: srai x6,x7,3 then sw x2,-4(x8)
    out_ready = 1'b1;
    expect_word(32'h4033_D313, 1'b0, 1'b1);
    send(3'b000, 7'h13, 3'b101, 7'h20, 5'd6, 5'd7, 5'd0, 32'd3);
    check_out(e);
    expect_word(32'hFE24_2E23, 1'b0, 1'b1);
    send(3'b001, 7'h23, 3'b010, 7'd0, 5'd0, 5'd8, 5'd2, 32'hFFFF_FFFC);
    check_out(e);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Reset while the ADDI half of an LI is pending
    send(3'b111, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    chk("slo_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #2;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_instr", out_instr, 32'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_addi", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    // U-type after reset
    expect_word(32'h0000_1137, 1'b0, 1'b1);
    send(3'b010, 7'h37, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h0000_1000);
    recv(0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
